// File: rtl/alu_op_sequencer_if.sv
// Command, datapath and result bundle for the ALU op sequencer.
// slave = the sequencer; master = command source, datapath and result consumer.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_muxindex;
  logic             alu_sub;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carryout;
  logic             alu_overflow;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_carryout;
  logic             res_overflow;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_a, alu_b, alu_muxindex, alu_sub,
    output alu_result, alu_carryout, alu_overflow,
    input  res_valid, res_data, res_zero, res_carryout, res_overflow,
    output res_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    output cmd_ready,
    output alu_a, alu_b, alu_muxindex, alu_sub,
    input  alu_result, alu_carryout, alu_overflow,
    output res_valid, res_data, res_zero, res_carryout, res_overflow,
    input  res_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Decodes ALU commands, holds operands stable while the structural datapath
// settles for SETTLE_CYCLES, then captures result and flags for the consumer.
module alu_op_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

  typedef struct packed {
    logic [2:0] mux;
    logic       sub;
  } dec_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  function automatic dec_t decode(input logic [2:0] op);
    dec_t d;
    case (op)
      3'd0:    d = '{mux: 3'd0, sub: 1'b0};  // ADD
      3'd1:    d = '{mux: 3'd0, sub: 1'b1};  // SUB
      3'd2:    d = '{mux: 3'd1, sub: 1'b0};  // XOR
      3'd3:    d = '{mux: 3'd2, sub: 1'b1};  // SLT compares via subtraction
      3'd4:    d = '{mux: 3'd3, sub: 1'b0};  // AND
      3'd5:    d = '{mux: 3'd4, sub: 1'b0};  // NAND
      3'd6:    d = '{mux: 3'd5, sub: 1'b0};  // NOR
      default: d = '{mux: 3'd6, sub: 1'b0};  // OR
    endcase
    return d;
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_muxindex_q, alu_muxindex_d;
  logic             alu_sub_q, alu_sub_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_carryout_q, res_carryout_d;
  logic             res_overflow_q, res_overflow_d;

  logic cmd_ready;
  logic accept;
  logic adder_op;
  dec_t dec;

  assign cmd_ready = !reset && (state_q == IDLE || (state_q == HOLD && bus.res_ready));
  assign accept    = bus.cmd_valid && cmd_ready;
  // Only ADD and SUB route the adder through select 0, so its flags are meaningful only there.
  assign adder_op  = (alu_muxindex_q == 3'd0);
  assign dec       = decode(bus.cmd_op);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_muxindex_d = alu_muxindex_q;
    alu_sub_d      = alu_sub_q;
    res_valid_d    = res_valid_q;
    res_data_d     = res_data_q;
    res_zero_d     = res_zero_q;
    res_carryout_d = res_carryout_q;
    res_overflow_d = res_overflow_q;

    case (state_q)
      IDLE: ;
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          res_data_d     = bus.alu_result;
          res_zero_d     = (bus.alu_result == '0);
          res_carryout_d = bus.alu_carryout && adder_op;
          res_overflow_d = bus.alu_overflow && adder_op;
          res_valid_d    = 1'b1;
          state_d        = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // cmd_ready already restricts accepts to IDLE or a draining HOLD.
    if (accept) begin
      alu_a_d        = bus.cmd_a;
      alu_b_d        = bus.cmd_b;
      alu_muxindex_d = dec.mux;
      alu_sub_d      = dec.sub;
      cnt_d          = CNT_LOAD;
      state_d        = SETTLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_muxindex_q <= '0;
      alu_sub_q      <= 1'b0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_zero_q     <= 1'b0;
      res_carryout_q <= 1'b0;
      res_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_muxindex_q <= alu_muxindex_d;
      alu_sub_q      <= alu_sub_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      res_zero_q     <= res_zero_d;
      res_carryout_q <= res_carryout_d;
      res_overflow_q <= res_overflow_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_muxindex = alu_muxindex_q;
  assign bus.alu_sub      = alu_sub_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_zero     = res_zero_q;
  assign bus.res_carryout = res_carryout_q;
  assign bus.res_overflow = res_overflow_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: behavioural datapath drives alu_result/flags, a scoreboard
// queue holds expected results computed from opcode semantics.
module tb_alu_op_sequencer;
  localparam int W = 32;
  localparam int S = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(W)) bus ();
  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Behavioural stand-in for the structural datapath; force_flags pins both
  // flags high so masking on non-adder ops is visible.
  logic         force_flags;
  logic [W-1:0] bx;
  logic [W:0]   sum;
  always_comb begin
    bx  = bus.alu_sub ? ~bus.alu_b : bus.alu_b;
    sum = {1'b0, bus.alu_a} + {1'b0, bx} + {{W{1'b0}}, bus.alu_sub};
    case (bus.alu_muxindex)
      3'd0:    bus.alu_result = sum[W-1:0];
      3'd1:    bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'd2:    bus.alu_result = {{(W-1){1'b0}}, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      3'd3:    bus.alu_result = bus.alu_a & bus.alu_b;
      3'd4:    bus.alu_result = ~(bus.alu_a & bus.alu_b);
      3'd5:    bus.alu_result = ~(bus.alu_a | bus.alu_b);
      3'd6:    bus.alu_result = bus.alu_a | bus.alu_b;
      default: bus.alu_result = '0;
    endcase
    bus.alu_carryout = sum[W] | force_flags;
    bus.alu_overflow = ((bus.alu_a[W-1] == bx[W-1]) && (sum[W-1] != bus.alu_a[W-1])) | force_flags;
  end

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       e;
    logic [W:0] t;
    e.co = 1'b0;
    e.ov = 1'b0;
    case (op)
      3'd0: begin
        t = {1'b0, a} + {1'b0, b};
        e.data = t[W-1:0];
        e.co   = t[W];
        e.ov   = (a[W-1] == b[W-1]) && (e.data[W-1] != a[W-1]);
      end
      3'd1: begin
        e.data = a - b;
        e.co   = (a >= b);
        e.ov   = (a[W-1] != b[W-1]) && (e.data[W-1] != a[W-1]);
      end
      3'd2:    e.data = a ^ b;
      3'd3:    e.data = ($signed(a) < $signed(b)) ? 1 : 0;
      3'd4:    e.data = a & b;
      3'd5:    e.data = ~(a & b);
      3'd6:    e.data = ~(a | b);
      default: e.data = a | b;
    endcase
    e.zero = (e.data == '0);
    return e;
  endfunction

  function automatic logic [3:0] exp_dec(input logic [2:0] op);
    case (op)
      3'd0:    return {3'd0, 1'b0};
      3'd1:    return {3'd0, 1'b1};
      3'd2:    return {3'd1, 1'b0};
      3'd3:    return {3'd2, 1'b1};
      3'd4:    return {3'd3, 1'b0};
      3'd5:    return {3'd4, 1'b0};
      3'd6:    return {3'd5, 1'b0};
      default: return {3'd6, 1'b0};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_alu_a"}, bus.alu_a, 0);
    check({tag, "_alu_b"}, bus.alu_b, 0);
    check({tag, "_mux"}, bus.alu_muxindex, 0);
    check({tag, "_sub"}, bus.alu_sub, 0);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_data"}, bus.res_data, 0);
    check({tag, "_res_zero"}, bus.res_zero, 0);
    check({tag, "_res_co"}, bus.res_carryout, 0);
    check({tag, "_res_ov"}, bus.res_overflow, 0);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 0);
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    int         n;
    logic [3:0] d;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    if (push) q.push_back(ref_model(op, a, b));
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.cmd_ready) check("send_timeout", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    d = exp_dec(op);
    check("alu_muxindex", bus.alu_muxindex, d[3:1]);
    check("alu_sub", bus.alu_sub, d[0]);
    check("alu_a", bus.alu_a, a);
    check("alu_b", bus.alu_b, b);
  endtask

  // Counts edges until res_valid is seen, then pops and compares the scoreboard.
  task automatic wait_result(output int lat);
    exp_t e;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.res_valid && lat < 50);
    if (!bus.res_valid) begin
      check("result_timeout", bus.res_valid, 1);
      return;
    end
    if (q.size() == 0) begin
      check("scoreboard_underflow", q.size(), 1);
      return;
    end
    e = q.pop_front();
    check("res_data", bus.res_data, e.data);
    check("res_zero", bus.res_zero, e.zero);
    check("res_carryout", bus.res_carryout, e.co);
    check("res_overflow", bus.res_overflow, e.ov);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat;
    int lat2;
    reset         = 1'b1;
    force_flags   = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    reset = 1'b0;
    #1;
    check("idle_cmd_ready", bus.cmd_ready, 1);

    // ADD wrapping to zero
    send(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    wait_result(lat);
    check("add_latency", lat, S);
    @(posedge clk); #1;
    check("add_consumed", bus.res_valid, 0);

    // SUB with signed overflow; result persists after consumption
    send(3'd1, 32'h8000_0000, 32'h0000_0001, 1);
    wait_result(lat);
    @(posedge clk); #1;
    check("sub_consumed", bus.res_valid, 0);
    check("sub_data_persist", bus.res_data, 32'h7FFF_FFFF);

    // SLT: adder flags forced high must not leak
    force_flags = 1'b1;
    send(3'd3, 32'hFFFF_FFFE, 32'h0000_0003, 1);
    wait_result(lat);
    force_flags = 1'b0;
    @(posedge clk); #1;

    // Backpressure on NOR with a pending OR
    bus.res_ready = 1'b0;
    force_flags   = 1'b1;
    send(3'd6, 32'h0, 32'h0, 1);
    wait_result(lat);
    check("nor_latency", lat, S);
    force_flags   = 1'b0;
    bus.cmd_op    = 3'd7;
    bus.cmd_a     = 32'h1234_0000;
    bus.cmd_b     = 32'h0000_5678;
    bus.cmd_valid = 1'b1;
    q.push_back(ref_model(3'd7, 32'h1234_0000, 32'h0000_5678));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_res_data", bus.res_data, 32'hFFFF_FFFF);
      check("bp_res_zero", bus.res_zero, 0);
      check("bp_cmd_ready", bus.cmd_ready, 0);
      check("bp_mux_held", bus.alu_muxindex, 3'd5);
    end
    bus.res_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("bp_drained", bus.res_valid, 0);
    check("bp_or_mux", bus.alu_muxindex, 3'd6);
    check("bp_or_a", bus.alu_a, 32'h1234_0000);
    wait_result(lat);
    check("or_latency", lat, S);

    // Back-to-back AND then queued XOR
    send(3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1);
    bus.cmd_op    = 3'd2;
    bus.cmd_a     = 32'hF0F0_F0F0;
    bus.cmd_b     = 32'h0FF0_0FF0;
    bus.cmd_valid = 1'b1;
    q.push_back(ref_model(3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0));
    wait_result(lat);
    check("and_latency", lat, S);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("b2b_consumed", bus.res_valid, 0);
    check("b2b_xor_mux", bus.alu_muxindex, 3'd1);
    wait_result(lat2);
    check("b2b_gap", lat2 + 1, S + 1);
    @(posedge clk); #1;

    // Reset in the second SETTLE cycle discards the command
    send(3'd0, 32'h5, 32'h6, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_cleared("midreset");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("aborted_no_valid", bus.res_valid, 0);
    end
    send(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1);
    wait_result(lat);
    check("post_reset_latency", lat, S);
    @(posedge clk); #1;

    check("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Control stage directly upstream of the ALU result multiplexer. It accepts ALU commands over a valid/ready handshake and decodes the opcode into the 3-bit mux select and the add/subtract control. It holds operands and controls stable while the gate-delayed structural datapath settles for a fixed number of cycles. It then captures the result and flags into an output register presented over a second valid/ready handshake.

Parameters:
WIDTH, 32, operand/result width
SETTLE_CYCLES, 4, cycles operands are held before result capture (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept command
cmd_op  input  3  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
alu_a  output  WIDTH  registered operand A to datapath
alu_b  output  WIDTH  registered operand B to datapath
alu_muxindex  output  3  result-mux select to datapath
alu_sub  output  1  adder subtract control (invert B, carry-in 1)
alu_result  input  WIDTH  result-mux output from datapath
alu_carryout  input  1  adder carry-out from datapath
alu_overflow  input  1  adder signed overflow from datapath
res_valid  output  1  result register holds unconsumed result
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  captured result
res_zero  output  1  res_data == 0
res_carryout  output  1  captured carry-out (ADD/SUB only, else 0)
res_overflow  output  1  captured overflow (ADD/SUB only, else 0)

Behaviour:
- Reset (synchronous, clk edge with reset=1): state IDLE, counter 0. All registered outputs are 0: alu_a, alu_b, alu_muxindex, alu_sub, res_valid, res_data, res_zero, res_carryout, res_overflow. cmd_ready is 0 while reset=1. Reset overrides all other activity, including mid-SETTLE or HOLD; an in-flight command is discarded.
- Opcode decode to (alu_muxindex, alu_sub):
  - ADD: (0, 0); SUB: (0, 1); XOR: (1, 0); SLT: (2, 1)
  - AND: (3, 0); NAND: (4, 0); NOR: (5, 0); OR: (6, 0)
  - Select 7 is never driven.
- Decode is registered together with the operands on command accept.
- FSM states: IDLE, SETTLE, HOLD.
  - cmd_ready = !reset && (IDLE || (HOLD && res_ready)).
  - Accept occurs when cmd_valid && cmd_ready at a clk edge. On accept, alu_a, alu_b, alu_muxindex and alu_sub are loaded, the counter is loaded with SETTLE_CYCLES-1, and the state moves to SETTLE.
  - SETTLE: if counter == 0, capture res_data = alu_result, res_zero = (alu_result == 0), res_carryout = alu_carryout && (op is ADD/SUB), res_overflow = alu_overflow && (op is ADD/SUB), set res_valid = 1, and move to HOLD. Otherwise decrement the counter. cmd_valid is ignored in this state.
  - HOLD: res_* are stable until res_valid && res_ready at a clk edge. On that handshake, res_valid clears and the state moves to IDLE. If a command is accepted in the same cycle, the state moves directly to SETTLE instead.
- Latency: res_valid rises exactly SETTLE_CYCLES edges after the accepting edge. Best-case throughput is one command per SETTLE_CYCLES+1 cycles.
- alu_* outputs change only on accept. They hold their value through SETTLE, HOLD and IDLE until the next accept.
- res_data/flags change only on capture or reset.
- Flags are never combinationally derived from the live alu_result after capture.

Test Plan:
- Reset then ADD a=0xFFFFFFFF, b=0x00000001 with res_ready=1 -> alu_muxindex=0, alu_sub=0; res_valid high 4 edges after accept; res_data=0, zero=1, carryout=1, overflow=0.
- SUB a=0x80000000, b=0x00000001 -> alu_sub=1; res_data=0x7FFFFFFF, zero=0, carryout=1, overflow=1.
- SLT a=0xFFFFFFFE, b=0x00000003 -> muxindex=2, sub=1; res_data=0x00000001, carryout=0, overflow=0 even though the datapath drives carryout=1.
- Backpressure: NOR a=0, b=0, res_ready=0 for 10 cycles -> muxindex=5; res_valid stays 1 with res_data=0xFFFFFFFF, zero=0, stable; cmd_ready=0 throughout; a pending OR command is accepted only on the cycle res_ready rises.
- Back-to-back: AND 0xF0F0F0F0 & 0x0FF00FF0, then a queued XOR, res_ready=1 -> results 0x00F000F0 then 0xFF00FF00; the second res_valid occurs 5 cycles after the first.
- Assert reset during the 2nd SETTLE cycle of an ADD -> next edge: all outputs 0, IDLE; no res_valid ever appears for the aborted command; the next command completes normally.
